// File: rtl/manhattan_dist_accum.sv
// Byte-serial Manhattan-distance accumulator for the K-means assignment path.
// Every subtract, negate and accumulate step shares one 8-bit carry-lookahead
// adder, which handles one byte per cycle.
// Optional build macro: MANHATTAN_SAT_EN. When it is defined, the accumulator
// saturates to all ones once it overflows.

module adder_8_bit (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_ci,
  output logic [7:0] o_sum,
  output logic       o_co
);
  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [8:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Generate/propagate carry recurrence; flattened into lookahead terms by synthesis
  always_comb begin
    w_c[0] = i_ci;
    for (int i = 0; i < 8; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  assign o_sum = w_p ^ w_c[7:0];
  assign o_co  = w_c[8];
endmodule

module manhattan_dist_accum #(
  parameter int unsigned DIM       = 4,
  parameter int unsigned ACC_BYTES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [7:0]             i_x_in,
  input  logic [7:0]             i_c_in,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [8*ACC_BYTES-1:0] o_dist,
  output logic                   o_overflow,
  output logic                   o_busy
);
  localparam int unsigned AccW     = 8 * ACC_BYTES;
  localparam logic [1:0]  KLast    = 2'(ACC_BYTES - 1);
  localparam logic [7:0]  ElemLast = 8'(DIM - 1);

  typedef enum logic [2:0] {StIdle, StAccept, StSub, StNeg, StAdd, StDone} state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [7:0]        r_x;
  logic [7:0]        r_c;
  logic [7:0]        r_diff;
  logic [7:0]        r_elem;
  logic [1:0]        r_k;
  logic              r_carry;
  logic              r_ovf;
  logic [AccW-1:0]   r_acc;

  logic [7:0]        w_a;
  logic [7:0]        w_b;
  logic              w_ci;
  logic [7:0]        w_sum;
  logic              w_co;
  logic [7:0]        w_acc_byte;

  adder_8_bit u_adder (
    .i_a   (w_a),
    .i_b   (w_b),
    .i_ci  (w_ci),
    .o_sum (w_sum),
    .o_co  (w_co)
  );

  // Select the accumulator byte addressed by the byte counter
  always_comb begin
    w_acc_byte = '0;
    for (int i = 0; i < int'(ACC_BYTES); i++) begin
      if (r_k == 2'(i)) w_acc_byte = r_acc[8*i +: 8];
    end
  end

  // Adder operands: x-c in SUB, c-x in NEG, byte-wise accumulate in ADD
  always_comb begin
    w_a  = '0;
    w_b  = '0;
    w_ci = 1'b0;
    unique case (r_state)
      StSub: begin
        w_a  = r_x;
        w_b  = ~r_c;
        w_ci = 1'b1;
      end
      StNeg: begin
        w_a  = r_c;
        w_b  = ~r_x;
        w_ci = 1'b1;
      end
      StAdd: begin
        w_a = w_acc_byte;
        if (r_k == 2'd0) w_b = r_diff;
        else             w_ci = r_carry;
      end
      default: ;
    endcase
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (i_start) w_state_nxt = StAccept;
      StAccept: if (i_in_valid) w_state_nxt = StSub;
      StSub:    w_state_nxt = w_co ? StAdd : StNeg;  // no carry out means x < c
      StNeg:    w_state_nxt = StAdd;
      StAdd: begin
        if (r_k == KLast) w_state_nxt = (r_elem == ElemLast) ? StDone : StAccept;
      end
      StDone:   if (i_out_ready) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_x     <= '0;
      r_c     <= '0;
      r_diff  <= '0;
      r_elem  <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_elem  <= '0;
            r_k     <= '0;
            r_carry <= 1'b0;
          end
        end
        StAccept: begin
          if (i_in_valid) begin
            r_x <= i_x_in;
            r_c <= i_c_in;
          end
        end
        StSub: if (w_co) r_diff <= w_sum;
        StNeg: r_diff <= w_sum;
        StAdd: begin
          r_carry <= w_co;
`ifdef MANHATTAN_SAT_EN
          // A saturated accumulator is frozen at all ones for the rest of the distance
          if (!r_ovf) begin
            for (int i = 0; i < int'(ACC_BYTES); i++) begin
              if (r_k == 2'(i)) r_acc[8*i +: 8] <= w_sum;
            end
          end
          if ((r_k == KLast) && w_co) r_acc <= '1;
`else
          for (int i = 0; i < int'(ACC_BYTES); i++) begin
            if (r_k == 2'(i)) r_acc[8*i +: 8] <= w_sum;
          end
`endif
          if (r_k == KLast) begin
            if (w_co) r_ovf <= 1'b1;
            r_k <= '0;
            if (r_elem != ElemLast) r_elem <= r_elem + 8'd1;
          end else begin
            r_k <= r_k + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready  = (r_state == StAccept);
  assign o_out_valid = (r_state == StDone);
  assign o_busy      = (r_state != StIdle);
  assign o_dist      = r_acc;
  assign o_overflow  = r_ovf;
endmodule

// File: tb/tb_manhattan_dist_accum.sv
// Directed testbench for manhattan_dist_accum.
// Instance a uses ACC_BYTES=2 and instance b uses ACC_BYTES=1.
// Each distance pushes its expected result into a queue, and the entry is
// popped and compared when the DUT asserts out_valid.

module tb_manhattan_dist_accum;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, in_valid_a, out_ready_a, in_ready_a, out_valid_a, ovf_a, busy_a;
  logic        start_b, in_valid_b, out_ready_b, in_ready_b, out_valid_b, ovf_b, busy_b;
  logic [7:0]  x_a, c_a, x_b, c_b;
  logic [15:0] dist_a;
  logic [7:0]  dist_b;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb_dist[$];
  logic        sb_ovf[$];
  logic [7:0]  px[4];
  logic [7:0]  pc[4];

  manhattan_dist_accum #(.DIM(4), .ACC_BYTES(2)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_in_valid(in_valid_a),
    .o_in_ready(in_ready_a), .i_x_in(x_a), .i_c_in(c_a), .o_out_valid(out_valid_a),
    .i_out_ready(out_ready_a), .o_dist(dist_a), .o_overflow(ovf_a), .o_busy(busy_a)
  );

  manhattan_dist_accum #(.DIM(4), .ACC_BYTES(1)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_in_valid(in_valid_b),
    .o_in_ready(in_ready_b), .i_x_in(x_b), .i_c_in(c_b), .o_out_valid(out_valid_b),
    .i_out_ready(out_ready_b), .o_dist(dist_b), .o_overflow(ovf_b), .o_busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd_dist(input int s);
    return (s == 0) ? {16'b0, dist_a} : {24'b0, dist_b};
  endfunction
  function automatic logic rd_ir(input int s);
    return (s == 0) ? in_ready_a : in_ready_b;
  endfunction
  function automatic logic rd_ov(input int s);
    return (s == 0) ? out_valid_a : out_valid_b;
  endfunction
  function automatic logic rd_busy(input int s);
    return (s == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic rd_ovf(input int s);
    return (s == 0) ? ovf_a : ovf_b;
  endfunction

  task automatic set_start(input int s, input logic v);
    if (s == 0) start_a = v; else start_b = v;
  endtask
  task automatic set_ordy(input int s, input logic v);
    if (s == 0) out_ready_a = v; else out_ready_b = v;
  endtask
  task automatic set_in(input int s, input logic v, input logic [7:0] x, input logic [7:0] c);
    if (s == 0) begin in_valid_a = v; x_a = x; c_a = c; end
    else        begin in_valid_b = v; x_b = x; c_b = c; end
  endtask

  // Handshake one pair, then count cycles until in_ready or out_valid returns.
  task automatic send(input int s, input logic [7:0] x, input logic [7:0] c, input string tag);
    int n;
    int gap;
    int nbytes;
    nbytes = (s == 0) ? 2 : 1;
    n = 0;
    while (!rd_ir(s) && n < 100) begin tick(); n++; end
    check({tag, "_ready"}, {31'b0, rd_ir(s)}, 32'd1);
    set_in(s, 1'b1, x, c);
    tick();
    set_in(s, 1'b0, 8'd0, 8'd0);
    gap = 1;
    while (!rd_ir(s) && !rd_ov(s) && gap < 50) begin tick(); gap++; end
    check({tag, "_gap"}, gap, 1 + ((x < c) ? 2 : 1) + nbytes);
  endtask

  // One full distance: start, four pairs, optional ACCEPT stall, DONE hold and release.
  task automatic run(input int s, input bit stall, input string tag);
    int total;
    int part;
    longint modv;
    logic [31:0] ed;
    logic eo;
    logic [31:0] pd;
    logic po;
    int n;
    modv = (s == 0) ? 64'd65536 : 64'd256;
    total = 0;
    for (int i = 0; i < 4; i++) total += (px[i] >= pc[i]) ? int'(px[i] - pc[i]) : int'(pc[i] - px[i]);
    eo = (longint'(total) >= modv);
    ed = 32'(longint'(total) % modv);
`ifdef MANHATTAN_SAT_EN
    if (eo) ed = 32'(modv - 1);
`endif
    sb_dist.push_back(ed);
    sb_ovf.push_back(eo);

    set_start(s, 1'b1);
    tick();
    set_start(s, 1'b0);
    part = 0;
    for (int i = 0; i < 4; i++) begin
      send(s, px[i], pc[i], $sformatf("%s_e%0d", tag, i));
      part += (px[i] >= pc[i]) ? int'(px[i] - pc[i]) : int'(pc[i] - px[i]);
      if (stall && i == 1) begin
        for (int j = 0; j < 10; j++) begin
          if (j == 3) set_start(s, 1'b1);
          tick();
          set_start(s, 1'b0);
          check({tag, "_stall_rdy"}, {31'b0, rd_ir(s)}, 32'd1);
        end
        check({tag, "_stall_busy"}, {31'b0, rd_busy(s)}, 32'd1);
        check({tag, "_stall_dist"}, rd_dist(s), 32'(part));
      end
    end

    n = 0;
    while (!rd_ov(s) && n < 100) begin tick(); n++; end
    pd = sb_dist.pop_front();
    po = sb_ovf.pop_front();
    check({tag, "_out_valid"}, {31'b0, rd_ov(s)}, 32'd1);
    check({tag, "_dist"}, rd_dist(s), pd);
    check({tag, "_ovf"}, {31'b0, rd_ovf(s)}, {31'b0, po});
    for (int j = 0; j < 10; j++) begin
      tick();
      check({tag, "_hold_valid"}, {31'b0, rd_ov(s)}, 32'd1);
    end
    check({tag, "_hold_dist"}, rd_dist(s), pd);
    // start coinciding with out_ready in DONE must be dropped
    set_ordy(s, 1'b1);
    set_start(s, 1'b1);
    tick();
    set_ordy(s, 1'b0);
    set_start(s, 1'b0);
    check({tag, "_rel_valid"}, {31'b0, rd_ov(s)}, 32'd0);
    check({tag, "_rel_busy"}, {31'b0, rd_busy(s)}, 32'd0);
    tick();
    check({tag, "_drop_busy"}, {31'b0, rd_busy(s)}, 32'd0);
    check({tag, "_keep_dist"}, rd_dist(s), pd);
    check({tag, "_keep_ovf"}, {31'b0, rd_ovf(s)}, {31'b0, po});
  endtask

  task automatic check_reset(input int s, input string tag);
    check({tag, "_rdy"}, {31'b0, rd_ir(s)}, 32'd0);
    check({tag, "_ov"}, {31'b0, rd_ov(s)}, 32'd0);
    check({tag, "_busy"}, {31'b0, rd_busy(s)}, 32'd0);
    check({tag, "_dist"}, rd_dist(s), 32'd0);
    check({tag, "_ovf"}, {31'b0, rd_ovf(s)}, 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start_a = 1'b0; out_ready_a = 1'b0; set_in(0, 1'b0, 8'd0, 8'd0);
    start_b = 1'b0; out_ready_b = 1'b0; set_in(1, 1'b0, 8'd0, 8'd0);
    tick();
    tick();
    rst_n = 1'b1;
    check_reset(0, "rst_a");
    check_reset(1, "rst_b");
    tick();

    // Mixed pairs with an ACCEPT stall: 7+7+200+255 = 469
    px = '{8'd10, 8'd3, 8'd200, 8'd0};
    pc = '{8'd3, 8'd10, 8'd0, 8'd255};
    run(0, 1'b1, "mixed");

    // Equal pairs take the SUB path only
    px = '{8'd77, 8'd77, 8'd77, 8'd77};
    pc = '{8'd77, 8'd77, 8'd77, 8'd77};
    run(0, 1'b0, "equal");

    // Single-byte accumulator overflow
    px = '{8'd255, 8'd255, 8'd255, 8'd255};
    pc = '{8'd0, 8'd0, 8'd0, 8'd0};
    run(1, 1'b0, "wrap");

    // Carry into byte 1: 255+255 = 0x1FE
    px = '{8'd0, 8'd0, 8'd0, 8'd0};
    pc = '{8'd255, 8'd255, 8'd0, 8'd0};
    run(0, 1'b0, "carry");

    // Reset while element 2 is in NEG
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    send(0, 8'd1, 8'd2, "abort_e0");
    send(0, 8'd1, 8'd2, "abort_e1");
    n = 0;
    while (!in_ready_a && n < 100) begin tick(); n++; end
    set_in(0, 1'b1, 8'd3, 8'd10);
    tick();
    set_in(0, 1'b0, 8'd0, 8'd0);
    tick();
    check("abort_busy", {31'b0, busy_a}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset(0, "mid_rst_a");
    check_reset(1, "mid_rst_b");
    tick();
    check("mid_rst_idle", {31'b0, busy_a}, 32'd0);

    px = '{8'd5, 8'd5, 8'd5, 8'd5};
    pc = '{8'd1, 8'd1, 8'd1, 8'd1};
    run(0, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/manhattan_dist_accum.md
Name: manhattan_dist_accum

Overview:
- Byte-serial Manhattan-distance engine for the K-means assignment path.
- Accepts DIM (point, centroid) 8-bit unsigned coordinate pairs and forms |x-c| for each pair.
- Accumulates the differences into a (8*ACC_BYTES)-bit distance and presents it to the centroid comparator through a valid/ready handshake.
- All arithmetic runs through a single instance of the team's 8-bit carry-lookahead adder (adder_8_bit), time-multiplexed one byte per cycle.

Parameters:
- DIM, 4, coordinate pairs per distance; 1..255.
- ACC_BYTES, 2, accumulator width in bytes; 1..4; dist width is 8*ACC_BYTES.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; clears the accumulator and begins a new distance; honoured only in IDLE.
- in_valid  in  1  x/c pair valid.
- in_ready  out  1  block can take a pair; high only in ACCEPT.
- x_in  in  8  point coordinate, unsigned.
- c_in  in  8  centroid coordinate, unsigned.
- out_valid  out  1  dist/overflow valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- dist  out  8*ACC_BYTES  accumulated distance.
- overflow  out  1  sticky; accumulator carried out of its top byte during this distance.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge, in any state, including mid-operation):
  - State goes to IDLE.
  - in_ready=0, out_valid=0, busy=0, dist=0, overflow=0.
  - Element counter, byte counter and carry flop are cleared.
- Adder port is driven combinationally from state; the adder's sum/c0 are registered at the clock edge.
- IDLE:
  - On start, clear acc, overflow and the element counter, then go to ACCEPT.
  - start in any other state is ignored.
- ACCEPT:
  - in_ready=1.
  - On in_valid&in_ready, latch x_in/c_in and go to SUB.
  - Without in_valid, wait indefinitely.
- SUB:
  - Adder drive: a=x, b=~c, ci=1.
  - If c0=1 (x>=c), diff<=sum and go to ADD.
  - If c0=0, go to NEG.
  - x==c gives diff=0 through SUB.
- NEG:
  - Adder drive: a=c, b=~x, ci=1.
  - diff<=sum, then go to ADD.
- ADD: byte counter k runs 0..ACC_BYTES-1, one byte per cycle.
  - k=0: a=acc[7:0], b=diff, ci=0.
  - k>0: a=acc byte k, b=0, ci=carry.
  - Each cycle: acc byte k<=sum, carry<=c0.
  - At k=ACC_BYTES-1, c0=1 sets overflow.
  - After the last byte: if element counter==DIM-1, go to DONE; else increment the counter and go to ACCEPT.
- DONE:
  - out_valid=1; dist and overflow held stable.
  - On out_ready, go to IDLE (dist/overflow keep their value until the next start).
- Per-element latency from the handshake to the next in_ready:
  - 1+1+ACC_BYTES cycles when x>=c.
  - 1+2+ACC_BYTES cycles when x<c.
- The final element's ADD completes, then out_valid rises the next cycle.
- Wrap-around: without the optional feature, acc wraps modulo 2^(8*ACC_BYTES), and overflow stays set through DONE.
- Simultaneous start and out_ready while in DONE: go to IDLE; the start is dropped and must be reissued.

Optional Feature:
- Macro: MANHATTAN_SAT_EN.
- Defined:
  - Once overflow is set, acc is forced to all ones at the end of that ADD sequence.
  - All later ADD sequences in the same distance leave acc at all ones.
  - dist in DONE reads 2^(8*ACC_BYTES)-1; overflow still reported.
- Undefined: wrap behaviour as in Behaviour; no saturation logic is synthesised.

Test Plan:
- DIM=4, ACC_BYTES=2; pairs (10,3), (3,10), (200,0), (0,255) -> dist=0x01D5 (469), overflow=0, out_valid held until out_ready; per-element gaps of 4, 5, 4, 5 cycles.
- All pairs equal, (77,77)x4 -> dist=0, every element takes the SUB path only (4 cycles each).
- ACC_BYTES=1, DIM=4, pairs (255,0)x4 -> without the macro dist=0xFC, overflow=1; with MANHATTAN_SAT_EN dist=0xFF, overflow=1.
- ACC_BYTES=2, pairs (0,255)x2 -> dist=0x01FE; confirms carry propagation into byte 1 on the k=1 cycle.
- rst_n low for one cycle during NEG of element 2 -> next cycle all outputs 0, state IDLE; a new start followed by (5,1)x4 gives dist=16.
- Hold in_valid=0 for 10 cycles in ACCEPT, and out_ready=0 for 10 cycles in DONE -> no state change, outputs stable; start pulses during busy are ignored.
